sim_uart_tx: RTL and testbench
==============================

# sim_uart_tx

Synthesizable UART transmitter used on the testbench side of the Verilator and FPGA chip tops. It drives the chip's UART RX pad (MIO 25) from a small byte FIFO, as a pin-level stimulus source that does not need a DPI call per bit. Bit timing is derived from the same artificial clock and baud pair that on-chip software uses: 500 kHz and 7200 baud.

## Interface

Parameters:
- ClkFreq, 500_000: clk_i frequency in Hz.
- Baud, 7_200: line rate. ClksPerBit = ClkFreq / Baud, using integer division (69 by default). Elaboration fails if ClksPerBit < 2.
- FifoDepth, 4: byte FIFO entries. Must be ≥ 1.
- ParityEn, 0: 1 inserts a parity bit after the data bits.
- ParityOdd, 0: 0 selects even parity, 1 selects odd parity.
- StopBits, 1: number of stop bits, 1 or 2. Any other value fails elaboration.

Ports:
- clk_i, input, 1: single clock for all logic.
- rst_ni, input, 1: reset, asynchronous and active-low.
- active_i, input, 1: enable. When low, no new frame starts; a frame already in progress completes.
- wdata_i, input, 8: byte to enqueue.
- wvalid_i, input, 1: enqueue request.
- wready_o, output, 1: FIFO not full. A byte is accepted on a clock edge where wvalid_i and wready_o are both high.
- tx_o, output, 1: serial line to the chip's uart_rx. Idles high.
- busy_o, output, 1: high while any frame bit is being driven.
- fifo_depth_o, output, $clog2(FifoDepth+1): number of occupied FIFO entries.

## Operation

- FIFO:
  - Synchronous, first-word fall-through internally.
  - Push when wvalid_i && wready_o. Pop on the transition from Idle to Start.
  - wready_o = (depth != FifoDepth). It is low when full, even if a pop occurs in the same cycle: there is no full pass-through.
  - A simultaneous push and pop on a non-full FIFO leaves the depth unchanged.
  - A push while full is ignored; data is dropped and no error is flagged.
- FSM states, with a bit counter and a cycle counter:
  - Idle: tx_o = 1. Moves to Start when depth > 0 and active_i is high. The head byte is loaded into an 8-bit shift register on that move.
  - Start: tx_o = 0 for ClksPerBit cycles.
  - Data: 8 bits sent LSB first, each for ClksPerBit cycles.
  - Parity (only when ParityEn): tx_o = ^data XOR ParityOdd, for ClksPerBit cycles.
  - Stop: tx_o = 1 for StopBits × ClksPerBit cycles.
  - At the end of Stop: if depth > 0 and active_i is high, go directly to Start (pop and load), inserting no idle cycle. Otherwise go to Idle.
- active_i:
  - Sampled only at Idle→Start and Stop→Start decisions.
  - Dropping it mid-frame does not truncate the frame.
- Cycle counter: counts 0 to ClksPerBit−1, wraps, and advances the bit index on wrap.
- tx_o is driven from a flop, so it is glitch-free.
- busy_o = (state != Idle).

## Timing

- Reset values: tx_o = 1, busy_o = 0, wready_o = 1, fifo_depth_o = 0, FSM in Idle, FIFO empty.
- Reset assertion mid-frame:
  - tx_o returns to 1 asynchronously and the FIFO contents are discarded.
  - No partial-frame completion occurs after reset release.
- Latency: with the FIFO empty, Idle state and active_i high, a byte accepted at edge E makes tx_o fall at edge E+1. fifo_depth_o reads 1 after E and returns to 0 after E+1.
- Frame length in cycles: (1 + 8 + ParityEn + StopBits) × ClksPerBit. With default parameters this is 690 cycles.
- Back-to-back frames: the next start bit begins on the cycle immediately after the last stop cycle.
- fifo_depth_o updates on the edge after a push or pop.

## Test plan

- Reset, defaults, idle: hold rst_ni low, then release and idle 1000 cycles → tx_o = 1, busy_o = 0, wready_o = 1, fifo_depth_o = 0 throughout.
- Single byte 0x55, 8N1, ClksPerBit = 69:
  - Required line sequence: 0, 1, 0, 1, 0, 1, 0, 1, 0, 1, each held exactly 69 cycles.
  - The start-bit falling edge occurs 1 cycle after acceptance.
  - busy_o drops after 690 cycles.
- Parity with byte 0xA3:
  - ParityEn = 1, ParityOdd = 0 → parity bit 0.
  - ParityOdd = 1 → parity bit 1.
  - StopBits = 2 → stop held high for 138 cycles; frame length 828 cycles.
- FIFO full and back-to-back, FifoDepth = 4:
  - Push 0x01 through 0x05 in consecutive cycles.
  - Required: five bytes accepted (one is popped into the shifter first), after which wready_o = 0.
  - Further pushes are dropped.
  - The frames appear contiguously, 3450 cycles total, with no idle gap.
- active_i gating:
  - Push 0x10 and 0x20, then drop active_i during the first frame's data bits.
  - Required: frame 0x10 completes, then tx_o stays 1 and fifo_depth_o = 1.
  - Raising active_i starts 0x20 on the next cycle.
- Reset mid-frame: assert rst_ni at data bit 3 of 0xFF → tx_o = 1 immediately and fifo_depth_o = 0. After release, the line stays idle.

Source files
------------

// File: rtl/sim_uart_tx.sv
// Testbench-side UART transmitter: a small byte FIFO drains into a
// start/data/parity/stop serialiser whose line output comes straight from a flop.
module sim_uart_tx #(
  parameter int ClkFreq   = 500_000,
  parameter int Baud      = 7_200,
  parameter int FifoDepth = 4,
  parameter bit ParityEn  = 1'b0,
  parameter bit ParityOdd = 1'b0,
  parameter int StopBits  = 1
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           active_i,
  input  logic [7:0]                     wdata_i,
  input  logic                           wvalid_i,
  output logic                           wready_o,
  output logic                           tx_o,
  output logic                           busy_o,
  output logic [$clog2(FifoDepth+1)-1:0] fifo_depth_o
);

  localparam int ClksPerBit = ClkFreq / Baud;
  localparam int CntW       = (ClksPerBit > 1) ? $clog2(ClksPerBit) : 1;
  localparam int DepthW     = $clog2(FifoDepth + 1);
  localparam int PtrW       = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;

  localparam logic [CntW-1:0]   CycLast   = CntW'(ClksPerBit - 1);
  localparam logic [PtrW-1:0]   PtrLast   = PtrW'(FifoDepth - 1);
  localparam logic [DepthW-1:0] DepthFull = DepthW'(FifoDepth);
  localparam logic [2:0]        StopLast  = 3'(StopBits - 1);

  if (ClksPerBit < 2) begin : g_chk_clks
    $error("sim_uart_tx: ClkFreq / Baud must be at least 2");
  end
  if (FifoDepth < 1) begin : g_chk_depth
    $error("sim_uart_tx: FifoDepth must be at least 1");
  end
  if ((StopBits != 1) && (StopBits != 2)) begin : g_chk_stop
    $error("sim_uart_tx: StopBits must be 1 or 2");
  end

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_e;

  function automatic logic parity_bit(input logic [7:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
    logic [PtrW-1:0] nxt;
    if (ptr == PtrLast) begin
      nxt = {PtrW{1'b0}};
    end else begin
      nxt = ptr + PtrW'(1);
    end
    return nxt;
  endfunction

  logic [7:0]        mem_r [FifoDepth];
  logic [PtrW-1:0]   wr_ptr_r;
  logic [PtrW-1:0]   rd_ptr_r;
  logic [DepthW-1:0] count_r;
  logic [DepthW-1:0] count_s;
  logic              wready_r;
  logic              push_s;
  logic              pop_s;
  logic [7:0]        head_s;

  state_e            state_r;
  state_e            state_s;
  logic [CntW-1:0]   cyc_r;
  logic [CntW-1:0]   cyc_s;
  logic [2:0]        bit_r;
  logic [2:0]        bit_s;
  logic [7:0]        shift_r;
  logic [7:0]        shift_s;
  logic              par_r;
  logic              par_s;
  logic              tx_r;
  logic              tx_s;
  logic              busy_r;
  logic              cyc_wrap_s;
  logic              can_start_s;

  // No full pass-through: a pop in the same cycle does not reopen a full FIFO.
  assign push_s      = wvalid_i && wready_r;
  assign head_s      = mem_r[rd_ptr_r];
  assign cyc_wrap_s  = (cyc_r == CycLast);
  assign can_start_s = (count_r != {DepthW{1'b0}}) && active_i;

  // FIFO occupancy after this cycle's push and pop.
  always_comb begin
    count_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_s = count_r + DepthW'(1);
      2'b01:   count_s = count_r - DepthW'(1);
      default: count_s = count_r;
    endcase
  end

  // Frame sequencer: next state, bit/cycle counters and shifter load/shift.
  always_comb begin
    state_s = state_r;
    bit_s   = bit_r;
    shift_s = shift_r;
    par_s   = par_r;
    pop_s   = 1'b0;
    if (cyc_wrap_s) begin
      cyc_s = {CntW{1'b0}};
    end else begin
      cyc_s = cyc_r + CntW'(1);
    end
    case (state_r)
      ST_IDLE: begin
        cyc_s = {CntW{1'b0}};
        if (can_start_s) begin
          state_s = ST_START;
          pop_s   = 1'b1;
          shift_s = head_s;
          par_s   = parity_bit(head_s, ParityOdd);
          bit_s   = 3'd0;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_START: begin
        if (cyc_wrap_s) begin
          state_s = ST_DATA;
          bit_s   = 3'd0;
        end else begin
          state_s = ST_START;
        end
      end
      ST_DATA: begin
        if (cyc_wrap_s) begin
          shift_s = {1'b0, shift_r[7:1]};
          if (bit_r == 3'd7) begin
            bit_s = 3'd0;
            if (ParityEn) begin
              state_s = ST_PARITY;
            end else begin
              state_s = ST_STOP;
            end
          end else begin
            bit_s = bit_r + 3'd1;
          end
        end else begin
          state_s = ST_DATA;
        end
      end
      ST_PARITY: begin
        if (cyc_wrap_s) begin
          state_s = ST_STOP;
          bit_s   = 3'd0;
        end else begin
          state_s = ST_PARITY;
        end
      end
      ST_STOP: begin
        // The last stop cycle chains straight into the next start bit.
        if (cyc_wrap_s) begin
          if (bit_r == StopLast) begin
            if (can_start_s) begin
              state_s = ST_START;
              pop_s   = 1'b1;
              shift_s = head_s;
              par_s   = parity_bit(head_s, ParityOdd);
              bit_s   = 3'd0;
            end else begin
              state_s = ST_IDLE;
              bit_s   = 3'd0;
            end
          end else begin
            bit_s = bit_r + 3'd1;
          end
        end else begin
          state_s = ST_STOP;
        end
      end
      default: begin
        state_s = ST_IDLE;
        cyc_s   = {CntW{1'b0}};
        bit_s   = 3'd0;
      end
    endcase
  end

  // Line level for the cycle after the next edge.
  always_comb begin
    tx_s = 1'b1;
    case (state_s)
      ST_START:  tx_s = 1'b0;
      ST_DATA:   tx_s = shift_s[0];
      ST_PARITY: tx_s = par_s;
      default:   tx_s = 1'b1;
    endcase
  end

  // FIFO storage and pointers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < FifoDepth; i++) begin
        mem_r[i] <= 8'h00;
      end
      wr_ptr_r <= {PtrW{1'b0}};
      rd_ptr_r <= {PtrW{1'b0}};
      count_r  <= {DepthW{1'b0}};
      wready_r <= 1'b1;
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= wdata_i;
        wr_ptr_r        <= ptr_inc(wr_ptr_r);
      end
      if (pop_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      count_r  <= count_s;
      wready_r <= (count_s != DepthFull);
    end
  end

  // Sequencer state and registered line/busy outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r <= ST_IDLE;
      cyc_r   <= {CntW{1'b0}};
      bit_r   <= 3'd0;
      shift_r <= 8'h00;
      par_r   <= 1'b0;
      tx_r    <= 1'b1;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      cyc_r   <= cyc_s;
      bit_r   <= bit_s;
      shift_r <= shift_s;
      par_r   <= par_s;
      tx_r    <= tx_s;
      busy_r  <= (state_s != ST_IDLE);
    end
  end

  assign wready_o     = wready_r;
  assign tx_o         = tx_r;
  assign busy_o       = busy_r;
  assign fifo_depth_o = count_r;

endmodule

// File: tb/tb_sim_uart_tx.sv
// Self-checking bench for sim_uart_tx: a frame-level model checks the default
// 8N1 instance every cycle; two parity/stop variants are checked by directed samples.
module tb_sim_uart_tx;

  localparam int CPB  = 500_000 / 7_200;
  localparam int FL_A = 10 * CPB;

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b1;
  logic       active_a = 1'b1;
  logic [7:0] wdata_a  = 8'h00;
  logic       wvalid_a = 1'b0;
  logic       wready_a, tx_a, busy_a;
  logic [2:0] depth_a;

  logic       active_p = 1'b1;
  logic [7:0] wdata_p  = 8'h00;
  logic       wvalid_p = 1'b0;
  logic       wready_b, tx_b, busy_b;
  logic [2:0] depth_b;
  logic       wready_c, tx_c, busy_c;
  logic [2:0] depth_c;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sim_uart_tx u_dut_a (
    .clk_i(clk), .rst_ni(rst_n), .active_i(active_a), .wdata_i(wdata_a),
    .wvalid_i(wvalid_a), .wready_o(wready_a), .tx_o(tx_a), .busy_o(busy_a),
    .fifo_depth_o(depth_a)
  );

  sim_uart_tx #(.ParityEn(1'b1), .ParityOdd(1'b0), .StopBits(1)) u_dut_b (
    .clk_i(clk), .rst_ni(rst_n), .active_i(active_p), .wdata_i(wdata_p),
    .wvalid_i(wvalid_p), .wready_o(wready_b), .tx_o(tx_b), .busy_o(busy_b),
    .fifo_depth_o(depth_b)
  );

  sim_uart_tx #(.ParityEn(1'b1), .ParityOdd(1'b1), .StopBits(2)) u_dut_c (
    .clk_i(clk), .rst_ni(rst_n), .active_i(active_p), .wdata_i(wdata_p),
    .wvalid_i(wvalid_p), .wready_o(wready_c), .tx_o(tx_c), .busy_o(busy_c),
    .fifo_depth_o(depth_c)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Frame-level model of instance A: byte queue plus position inside the current frame.
  logic [7:0] mq[$];
  logic [7:0] m_byte   = 8'h00;
  bit         m_busy   = 1'b0;
  bit         m_accept = 1'b0;
  int         m_k      = 0;

  function automatic logic frame_bit(input logic [7:0] b, input int j);
    logic r;
    if (j == 0) r = 1'b0;
    else if (j <= 8) r = b[j-1];
    else r = 1'b1;
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_busy = 1'b0;
      m_k    = 0;
    end else begin
      m_accept = wvalid_a && (mq.size() != 4);
      if (m_busy) begin
        if (m_k == FL_A - 1) m_busy = 1'b0;
        else m_k++;
      end
      if (!m_busy && (mq.size() > 0) && active_a) begin
        m_byte = mq.pop_front();
        m_busy = 1'b1;
        m_k    = 0;
      end
      if (m_accept) mq.push_back(wdata_a);
    end
  end

  always @(negedge clk) begin
    check("model_tx", 32'(tx_a), 32'(m_busy ? frame_bit(m_byte, m_k / CPB) : 1'b1));
    check("model_busy", 32'(busy_a), 32'(m_busy));
    check("model_depth", 32'(depth_a), mq.size());
    check("model_wready", 32'(wready_a), 32'(mq.size() != 4));
  end

  int run_a = 0;
  int last_run_a = 0;
  always @(negedge clk) begin
    if (!rst_n) run_a = 0;
    else if (busy_a) run_a++;
    else if (run_a != 0) begin
      last_run_a = run_a;
      run_a = 0;
    end
  end

  logic       cap_tx_a [0:999];
  logic       cap_busy_a [0:999];
  logic [2:0] cap_dep_a [0:999];
  logic       cap_tx_b [0:999];
  logic       cap_busy_b [0:999];
  logic [2:0] cap_dep_b [0:999];
  logic       cap_tx_c [0:999];
  logic       cap_busy_c [0:999];
  logic [2:0] cap_dep_c [0:999];
  logic       cap_wr_b0, cap_wr_c0;

  task automatic capture(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cap_tx_a[i] = tx_a; cap_busy_a[i] = busy_a; cap_dep_a[i] = depth_a;
      cap_tx_b[i] = tx_b; cap_busy_b[i] = busy_b; cap_dep_b[i] = depth_b;
      cap_tx_c[i] = tx_c; cap_busy_c[i] = busy_c; cap_dep_c[i] = depth_c;
      if (i == 0) begin
        cap_wr_b0 = wready_b;
        cap_wr_c0 = wready_c;
        wvalid_a  = 1'b0;
        wvalid_p  = 1'b0;
      end
    end
  endtask

  task automatic wait_idle_a(input int bound);
    int n = 0;
    while (busy_a && (n < bound)) begin
      @(negedge clk);
      n++;
    end
    if (busy_a) check("idle_timeout", 32'(busy_a), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  logic [9:0]  exp_a;
  logic [10:0] exp_b;
  logic [11:0] exp_c;
  int nb, nc;

  initial begin
    exp_a = 10'b10_1010_1010;     // 0x55 8N1: start, 1,0,1,0,1,0,1,0, stop
    exp_b = 11'b101_0100_0110;    // 0xA3 8E1: parity 0
    exp_c = 12'b1111_0100_0110;   // 0xA3 8O2: parity 1, two stop bits

    #1 rst_n = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (1000) @(negedge clk);
    check("idle_tx", 32'(tx_a), 32'd1);
    check("idle_busy", 32'(busy_a), 32'd0);
    check("idle_wready", 32'(wready_a), 32'd1);
    check("idle_depth", 32'(depth_a), 32'd0);

    // Single byte 0x55, default 8N1.
    wdata_a = 8'h55; wvalid_a = 1'b1;
    capture(800);
    check("lat_tx_e", 32'(cap_tx_a[0]), 32'd1);
    check("lat_depth_e", 32'(cap_dep_a[0]), 32'd1);
    check("lat_tx_e1", 32'(cap_tx_a[1]), 32'd0);
    check("lat_depth_e1", 32'(cap_dep_a[1]), 32'd0);
    for (int b = 0; b < 10; b++) begin
      check("a_bit_first", 32'(cap_tx_a[1 + CPB * b]), 32'(exp_a[b]));
      check("a_bit_last", 32'(cap_tx_a[CPB * (b + 1)]), 32'(exp_a[b]));
    end
    check("a_busy_end", 32'(cap_busy_a[690]), 32'd1);
    check("a_busy_drop", 32'(cap_busy_a[691]), 32'd0);
    check("a_frame_len", last_run_a, 32'd690);

    // 0xA3 into the even-parity and odd-parity/two-stop instances together.
    wdata_p = 8'hA3; wvalid_p = 1'b1;
    capture(900);
    check("b_depth_e", 32'(cap_dep_b[0]), 32'd1);
    check("b_depth_e1", 32'(cap_dep_b[1]), 32'd0);
    check("c_depth_e1", 32'(cap_dep_c[1]), 32'd0);
    check("b_wready", 32'(cap_wr_b0), 32'd1);
    check("c_wready", 32'(cap_wr_c0), 32'd1);
    for (int b = 0; b < 11; b++) begin
      check("b_bit_first", 32'(cap_tx_b[1 + CPB * b]), 32'(exp_b[b]));
      check("b_bit_last", 32'(cap_tx_b[CPB * (b + 1)]), 32'(exp_b[b]));
    end
    for (int b = 0; b < 12; b++) begin
      check("c_bit_first", 32'(cap_tx_c[1 + CPB * b]), 32'(exp_c[b]));
      check("c_bit_last", 32'(cap_tx_c[CPB * (b + 1)]), 32'(exp_c[b]));
    end
    nb = 0; nc = 0;
    for (int i = 0; i < 900; i++) begin
      if (cap_busy_b[i]) nb++;
      if (cap_busy_c[i]) nc++;
    end
    check("b_frame_len", nb, 32'd759);
    check("c_frame_len", nc, 32'd828);
    check("c_busy_drop", 32'(cap_busy_c[829]), 32'd0);

    // FIFO full and back-to-back: 0x01..0x05 accepted, 0x06 and 0x07 dropped.
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      if (k == 5) begin
        check("full_wready", 32'(wready_a), 32'd0);
        check("full_depth", 32'(depth_a), 32'd4);
      end
      wdata_a = 8'(k + 1);
      wvalid_a = 1'b1;
    end
    @(negedge clk);
    wvalid_a = 1'b0;
    check("drop_depth", 32'(depth_a), 32'd4);
    wait_idle_a(5000);
    check("b2b_len", last_run_a, 32'd3450);

    // active_i gating between frames.
    @(negedge clk); wdata_a = 8'h10; wvalid_a = 1'b1;
    @(negedge clk); wdata_a = 8'h20;
    @(negedge clk); wvalid_a = 1'b0;
    repeat (200) @(negedge clk);
    active_a = 1'b0;
    wait_idle_a(2000);
    check("gate_len", last_run_a, 32'd690);
    repeat (100) @(negedge clk);
    check("gate_tx", 32'(tx_a), 32'd1);
    check("gate_busy", 32'(busy_a), 32'd0);
    check("gate_depth", 32'(depth_a), 32'd1);
    active_a = 1'b1;
    @(negedge clk);
    check("resume_tx", 32'(tx_a), 32'd0);
    check("resume_depth", 32'(depth_a), 32'd0);
    wait_idle_a(2000);
    check("resume_len", last_run_a, 32'd690);

    // Reset during data bit 3 of 0xFF with a second byte still queued.
    @(negedge clk); wdata_a = 8'hFF; wvalid_a = 1'b1;
    @(negedge clk);
    @(negedge clk); wvalid_a = 1'b0;
    repeat (300) @(negedge clk);
    check("pre_rst_busy", 32'(busy_a), 32'd1);
    check("pre_rst_depth", 32'(depth_a), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_tx", 32'(tx_a), 32'd1);
    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_depth", 32'(depth_a), 32'd0);
    check("rst_wready", 32'(wready_a), 32'd1);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (200) @(negedge clk);
    check("post_rst_tx", 32'(tx_a), 32'd1);
    check("post_rst_busy", 32'(busy_a), 32'd0);
    check("post_rst_depth", 32'(depth_a), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
